// File: rtl/mem_port_arbiter.sv
// Shares one backing memory port between instruction fetch and data load/store.
// Requests are bounds/alignment-checked, ties alternate, and a stuck ack times out.
module mem_port_arbiter #(
    parameter int MEM_BYTES = 262144,
    parameter int ADDR_W    = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_valid,
    output logic              instr_segv,
    output logic              wait_instr,
    input  logic              d_ld,
    input  logic              d_st,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              data_segv,
    output logic              wait_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [31:0]      LIMIT    = 32'(MEM_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t             r_state;
    logic               r_last_data;
    logic               r_gnt_data;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [31:0]        r_i_rdata;
    logic [31:0]        r_d_rdata;
    logic               r_i_valid;
    logic               r_d_valid;
    logic               r_i_segv;
    logic               r_d_segv;

    logic               w_d_req;
    logic               w_any_req;
    logic               w_pick_data;
    logic [31:0]        w_addr;
    logic               w_fault;

    assign w_d_req   = d_ld | d_st;
    assign w_any_req = i_req | w_d_req;

    // On a tie, data wins only if the previous grant went to instruction.
    assign w_pick_data = w_d_req & (~i_req | ~r_last_data);
    assign w_addr      = w_pick_data ? d_addr : i_addr;
    assign w_fault     = (w_addr[1:0] != 2'b00)
                       | (w_addr >= LIMIT)
                       | (w_pick_data & d_ld & d_st);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_last_data <= 1'b1;
            r_gnt_data  <= 1'b0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_valid   <= 1'b0;
            r_d_valid   <= 1'b0;
            r_i_segv    <= 1'b0;
            r_d_segv    <= 1'b0;
        end else begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_i_segv  <= 1'b0;
            r_d_segv  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_last_data <= w_pick_data;
                        r_gnt_data  <= w_pick_data;
                        r_cnt       <= '0;
                        if (w_fault) begin
                            r_state  <= RESP;
                            r_i_segv <= ~w_pick_data;
                            r_d_segv <= w_pick_data;
                        end else begin
                            r_state     <= BUSY;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= w_pick_data & d_st;
                            r_mem_addr  <= w_addr[ADDR_W+1:2];
                            r_mem_wdata <= d_wdata;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        r_state   <= RESP;
                        r_mem_req <= 1'b0;
                        if (r_gnt_data) begin
                            r_d_valid <= 1'b1;
                            if (!r_mem_we) begin
                                r_d_rdata <= mem_rdata;
                            end
                        end else begin
                            r_i_valid <= 1'b1;
                            r_i_rdata <= mem_rdata;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= RESP;
                        r_mem_req <= 1'b0;
                        r_i_segv  <= ~r_gnt_data;
                        r_d_segv  <= r_gnt_data;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign i_rdata    = r_i_rdata;
    assign d_rdata    = r_d_rdata;
    assign i_valid    = r_i_valid;
    assign d_valid    = r_d_valid;
    assign instr_segv = r_i_segv;
    assign data_segv  = r_d_segv;

    assign wait_instr = i_req & ~r_i_valid & ~r_i_segv;
    assign wait_data  = w_d_req & ~r_d_valid & ~r_d_segv;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed per-cycle vectors for mem_port_arbiter plus hand-written
// timeout and reset-during-transaction sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        instr_segv;
    logic        wait_instr;
    logic        d_ld;
    logic        d_st;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        data_segv;
    logic        wait_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_valid    (i_valid),
        .instr_segv (instr_segv),
        .wait_instr (wait_instr),
        .d_ld       (d_ld),
        .d_st       (d_st),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_valid    (d_valid),
        .data_segv  (data_segv),
        .wait_data  (wait_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        ld;
        logic        st;
        logic [31:0] da;
        logic [31:0] wd;
        logic        ak;
        logic [31:0] rd;
        logic        e_req;
        logic        e_we;
        logic [15:0] e_addr;
        logic [31:0] e_wdata;
        logic [5:0]  e_flags;
        logic [31:0] e_ir;
        logic [31:0] e_dr;
    } vec_t;

    vec_t vq[$];

    // e_flags = {i_valid, d_valid, instr_segv, data_segv, wait_instr, wait_data}
    function automatic vec_t v(
        input logic ir, input logic [31:0] ia,
        input logic ld, input logic st,
        input logic [31:0] da, input logic [31:0] wd,
        input logic ak, input logic [31:0] rd,
        input logic er, input logic ew,
        input logic [15:0] ea, input logic [31:0] ewd,
        input logic [5:0] fl,
        input logic [31:0] eir, input logic [31:0] edr);
        vec_t t;
        t.ir = ir; t.ia = ia; t.ld = ld; t.st = st;
        t.da = da; t.wd = wd; t.ak = ak; t.rd = rd;
        t.e_req = er; t.e_we = ew; t.e_addr = ea; t.e_wdata = ewd;
        t.e_flags = fl; t.e_ir = eir; t.e_dr = edr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = 0; d_ld = 0; d_st = 0;
        d_addr = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_req"},   32'(mem_req),    0);
        chk({tag, " mem_we"},    32'(mem_we),     0);
        chk({tag, " mem_addr"},  32'(mem_addr),   0);
        chk({tag, " mem_wdata"}, mem_wdata,       0);
        chk({tag, " i_valid"},   32'(i_valid),    0);
        chk({tag, " d_valid"},   32'(d_valid),    0);
        chk({tag, " i_segv"},    32'(instr_segv), 0);
        chk({tag, " d_segv"},    32'(data_segv),  0);
        chk({tag, " i_rdata"},   i_rdata,         0);
        chk({tag, " d_rdata"},   d_rdata,         0);
    endtask

    initial begin
        int hi;
        bit done;

        // Tie after reset goes to fetch, then the load.
        vq.push_back(v(1, 32'h200, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0));
        vq.push_back(v(1, 32'h200, 1, 0, 32'h10, 0, 1, 32'hA1, 1, 0, 16'h80, 0, 6'b000011, 0, 0));
        vq.push_back(v(1, 32'h200, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 6'b100001, 32'hA1, 0));
        vq.push_back(v(0, 0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 32'hA1, 0));
        vq.push_back(v(0, 0, 1, 0, 32'h10, 0, 1, 32'hB2, 1, 0, 16'h4, 0, 6'b000001, 32'hA1, 0));
        vq.push_back(v(0, 0, 1, 0, 32'h10, 0, 1, 32'hEE, 0, 0, 0, 0, 6'b010000, 32'hA1, 32'hB2));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'hFF, 0, 0, 0, 0, 6'b000000, 32'hA1, 32'hB2));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'hA1, 32'hB2));
        // Fetch alone, ack three cycles after mem_req.
        vq.push_back(v(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000010, 32'hA1, 32'hB2));
        vq.push_back(v(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 16'h40, 0, 6'b000010, 32'hA1, 32'hB2));
        vq.push_back(v(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 16'h40, 0, 6'b000010, 32'hA1, 32'hB2));
        vq.push_back(v(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 16'h40, 0, 6'b000010, 32'hA1, 32'hB2));
        vq.push_back(v(1, 32'h100, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 16'h40, 0, 6'b000010, 32'hA1, 32'hB2));
        vq.push_back(v(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 32'hDEADBEEF, 32'hB2));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'hDEADBEEF, 32'hB2));
        // Tie after a fetch grant goes to data (a store), then fetch.
        vq.push_back(v(1, 32'h300, 0, 1, 32'h20, 32'h55, 0, 0, 0, 0, 0, 0, 6'b000011, 32'hDEADBEEF, 32'hB2));
        vq.push_back(v(1, 32'h300, 0, 1, 32'h20, 32'h55, 1, 32'h99, 1, 1, 16'h8, 32'h55, 6'b000011, 32'hDEADBEEF, 32'hB2));
        vq.push_back(v(1, 32'h300, 0, 1, 32'h20, 32'h55, 0, 0, 0, 0, 0, 0, 6'b010010, 32'hDEADBEEF, 32'hB2));
        vq.push_back(v(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000010, 32'hDEADBEEF, 32'hB2));
        vq.push_back(v(1, 32'h300, 0, 0, 0, 0, 1, 32'hC3, 1, 0, 16'hC0, 0, 6'b000010, 32'hDEADBEEF, 32'hB2));
        vq.push_back(v(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 32'hC3, 32'hB2));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'hC3, 32'hB2));
        // Store with wdata held until a late ack.
        vq.push_back(v(0, 0, 0, 1, 32'h8, 32'h12345678, 0, 0, 0, 0, 0, 0, 6'b000001, 32'hC3, 32'hB2));
        vq.push_back(v(0, 0, 0, 1, 32'h8, 32'h12345678, 0, 0, 1, 1, 16'h2, 32'h12345678, 6'b000001, 32'hC3, 32'hB2));
        vq.push_back(v(0, 0, 0, 1, 32'h8, 32'h12345678, 0, 0, 1, 1, 16'h2, 32'h12345678, 6'b000001, 32'hC3, 32'hB2));
        vq.push_back(v(0, 0, 0, 1, 32'h8, 32'h12345678, 1, 32'hAAAA0000, 1, 1, 16'h2, 32'h12345678, 6'b000001, 32'hC3, 32'hB2));
        vq.push_back(v(0, 0, 0, 1, 32'h8, 32'h12345678, 0, 0, 0, 0, 0, 0, 6'b010000, 32'hC3, 32'hB2));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'hC3, 32'hB2));
        // Faults: misaligned load, out-of-range fetch, load+store together.
        vq.push_back(v(0, 0, 1, 0, 32'h6, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 32'hC3, 32'hB2));
        vq.push_back(v(0, 0, 1, 0, 32'h6, 0, 0, 0, 0, 0, 0, 0, 6'b000100, 32'hC3, 32'hB2));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'hC3, 32'hB2));
        vq.push_back(v(1, 32'h40000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000010, 32'hC3, 32'hB2));
        vq.push_back(v(1, 32'h40000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 32'hC3, 32'hB2));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'hC3, 32'hB2));
        vq.push_back(v(0, 0, 1, 1, 32'hC, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 32'hC3, 32'hB2));
        vq.push_back(v(0, 0, 1, 1, 32'hC, 0, 0, 0, 0, 0, 0, 0, 6'b000100, 32'hC3, 32'hB2));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'hC3, 32'hB2));
        // Last legal word.
        vq.push_back(v(1, 32'h3FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000010, 32'hC3, 32'hB2));
        vq.push_back(v(1, 32'h3FFFC, 0, 0, 0, 0, 1, 32'h77, 1, 0, 16'hFFFF, 0, 6'b000010, 32'hC3, 32'hB2));
        vq.push_back(v(1, 32'h3FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 32'h77, 32'hB2));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h77, 32'hB2));

        idle_inputs();
        reset_n = 0;
        tick();
        tick();
        #3;
        chk_all_zero("reset");
        chk("reset wait_i", 32'(wait_instr), 0);
        chk("reset wait_d", 32'(wait_data), 0);
        reset_n = 1;
        tick();

        for (int i = 0; i < vq.size(); i++) begin
            i_req = vq[i].ir; i_addr = vq[i].ia;
            d_ld = vq[i].ld; d_st = vq[i].st;
            d_addr = vq[i].da; d_wdata = vq[i].wd;
            mem_ack = vq[i].ak; mem_rdata = vq[i].rd;
            #3;
            chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vq[i].e_req));
            if (vq[i].e_req) begin
                chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vq[i].e_we));
                chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vq[i].e_addr));
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vq[i].e_wdata);
            end
            chk($sformatf("v%0d flags", i),
                32'({i_valid, d_valid, instr_segv, data_segv, wait_instr, wait_data}),
                32'(vq[i].e_flags));
            chk($sformatf("v%0d i_rdata", i), i_rdata, vq[i].e_ir);
            chk($sformatf("v%0d d_rdata", i), d_rdata, vq[i].e_dr);
            tick();
        end
        idle_inputs();

        // Timeout: mem_req must stay high exactly 255 cycles, then one segv.
        i_req = 1; i_addr = 32'h40;
        hi = 0;
        done = 0;
        for (int n = 0; n < 400 && !done; n++) begin
            #3;
            if (mem_req) hi++;
            else if (hi > 0) done = 1;
            if (!done) tick();
        end
        chk("timeout reached", 32'(done), 1);
        chk("timeout req cycles", hi, 255);
        chk("timeout segv", 32'(instr_segv), 1);
        chk("timeout no valid", 32'(i_valid), 0);
        chk("timeout wait_i", 32'(wait_instr), 0);
        tick();
        i_req = 0;
        #3;
        chk("timeout segv once", 32'(instr_segv), 0);
        tick();

        i_req = 1; i_addr = 32'h4;
        #3;
        tick();
        #3;
        chk("post-timeout req", 32'(mem_req), 1);
        chk("post-timeout addr", 32'(mem_addr), 1);
        mem_ack = 1; mem_rdata = 32'h5A5A5A5A;
        tick();
        mem_ack = 0;
        #3;
        chk("post-timeout valid", 32'(i_valid), 1);
        chk("post-timeout rdata", i_rdata, 32'h5A5A5A5A);
        tick();
        i_req = 0;
        tick();

        // Reset while a fetch is outstanding.
        i_req = 1; i_addr = 32'h8; d_wdata = 32'hCAFE0001;
        #3;
        tick();
        #3;
        chk("midbusy req", 32'(mem_req), 1);
        reset_n = 0;
        i_req = 0;
        tick();
        #3;
        chk_all_zero("midbusy reset");
        reset_n = 1;
        mem_ack = 1; mem_rdata = 32'h11111111;
        tick();
        mem_ack = 0;
        #3;
        chk("late ack valid0", 32'(i_valid), 0);
        chk("late ack req", 32'(mem_req), 0);
        tick();
        #3;
        chk("late ack valid1", 32'(i_valid), 0);
        chk("late ack rdata", i_rdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
